// File: rtl/decoder3to8_seq.sv
// Purpose : sequential 3:8 decoder; each accepted code is shown one-hot on out_y
//           for HOLD_CYCLES cycles, then GAP_CYCLES all-zero cycles.
// Latency : code accepted at edge k appears on out_y after edge k+1 when idle.
// Backpressure: one-entry pending register; in_ready = !pend_valid.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_code/in_valid    code to decode and its qualifier
//   in_ready            high while the pending register is empty
//   flush               synchronous abort of pending code and current output
//   out_y/out_valid     registered one-hot decode, valid when non-zero
//   busy                FSM not idle or a code is pending
//   out_cnt             number of codes driven onto out_y (wraps)
module decoder3to8_seq #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_y,
    output logic       out_valid,
    output logic       busy,
    output logic [7:0] out_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counter reload values: the counter holds "cycles remaining after this one".
    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam bit         HAS_GAP   = (GAP_CYCLES > 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] y_q, y_d;
    logic [7:0] out_cnt_q, out_cnt_d;
    logic [2:0] pend_code_q, pend_code_d;
    logic       pend_valid_q, pend_valid_d;
    logic       accept;
    logic       load;

    // Ready depends only on the registered pending flag, so a code being
    // drained this cycle does not open the input in the same cycle.
    assign in_ready  = !pend_valid_q;
    assign accept    = in_valid && in_ready;
    assign out_y     = y_q;
    assign out_valid = |y_q;
    assign busy      = (state_q != IDLE) || pend_valid_q;
    assign out_cnt   = out_cnt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        y_d          = y_q;
        out_cnt_d    = out_cnt_q;
        pend_code_d  = pend_code_q;
        pend_valid_d = pend_valid_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    load = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (HAS_GAP) begin
                    y_d     = 8'h00;
                    cnt_d   = GAP_LOAD;
                    state_d = GAP;
                end else if (pend_valid_q) begin
                    // No gap configured: next code follows with no zero cycle.
                    load = 1'b1;
                end else begin
                    y_d     = 8'h00;
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (pend_valid_q) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 8'h00;
                cnt_d   = 8'd0;
            end
        endcase

        if (load) begin
            y_d          = 8'b0000_0001 << pend_code_q;
            cnt_d        = HOLD_LOAD;
            state_d      = HOLD;
            out_cnt_d    = out_cnt_q + 8'd1;
            pend_valid_d = 1'b0;
        end

        // Accept and load are mutually exclusive: accept needs an empty
        // pending register, load needs a full one.
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_code_d  = in_code;
        end

        // Flush overrides everything except the delivered-code count.
        if (flush) begin
            state_d      = IDLE;
            cnt_d        = 8'd0;
            y_d          = 8'h00;
            pend_valid_d = 1'b0;
            out_cnt_d    = out_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            y_q          <= 8'h00;
            out_cnt_q    <= 8'd0;
            pend_code_q  <= 3'd0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            out_cnt_q    <= out_cnt_d;
            pend_code_q  <= pend_code_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_decoder3to8_seq.sv
module tb_decoder3to8_seq;

    logic       clk;
    logic       rst_n;

    // Instance A: HOLD=4, GAP=1
    logic [2:0] a_code;
    logic       a_vld, a_rdy, a_flush, a_ov, a_busy;
    logic [7:0] a_y, a_cnt;

    // Instance B: HOLD=4, GAP=0
    logic [2:0] b_code;
    logic       b_vld, b_rdy, b_flush, b_ov, b_busy;
    logic [7:0] b_y, b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_code(a_code), .in_valid(a_vld),
        .in_ready(a_rdy), .flush(a_flush), .out_y(a_y), .out_valid(a_ov),
        .busy(a_busy), .out_cnt(a_cnt)
    );

    decoder3to8_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_code(b_code), .in_valid(b_vld),
        .in_ready(b_rdy), .flush(b_flush), .out_y(b_y), .out_valid(b_ov),
        .busy(b_busy), .out_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       vld;
        logic [2:0] code;
        logic       fl;
        logic [7:0] y;
        logic       rdy;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[30];

    int         sw_codes[256];
    logic [7:0] rec[128];
    int         onehot_bad;
    int         ov_bad;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Streams sw_codes[0..n-1] into one instance with valid/ready handshake,
    // recording out_y after each edge.
    task automatic stream(input bit use_b, input int n, input int ncyc);
        int idx;
        logic v, r;
        logic [7:0] y;
        logic ov;
        idx = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            v = (idx < n);
            if (use_b) begin
                b_vld = v; b_code = 3'(sw_codes[idx % 256]); r = b_rdy;
            end else begin
                a_vld = v; a_code = 3'(sw_codes[idx % 256]); r = a_rdy;
            end
            @(posedge clk);
            #1;
            y  = use_b ? b_y : a_y;
            ov = use_b ? b_ov : a_ov;
            if (cyc < 128) rec[cyc] = y;
            if ($countones(y) > 1) onehot_bad++;
            if (ov !== (y != 8'h00)) ov_bad++;
            if (v && r) idx++;
        end
        @(negedge clk);
        a_vld = 1'b0;
        b_vld = 1'b0;
        chk($sformatf("stream_all_accepted_%0d", use_b), 8'(idx), 8'(n));
    endtask

    // Compares rec[] from its first non-zero sample against the expected
    // pattern: each code 4 cycles one-hot, then gap zero cycles, then idle zero.
    task automatic check_seq(input string nm, input int ncodes, input int gap);
        int start;
        int blk;
        logic [7:0] exp;
        start = -1;
        for (int i = 0; i < 128; i++) begin
            if (start < 0 && rec[i] != 8'h00) start = i;
        end
        if (start < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_start: out_y never non-zero, expected first value %h",
                     nm, 8'b1 << sw_codes[0]);
        end else begin
            blk = 4 + gap;
            for (int j = 0; j <= ncodes * blk; j++) begin
                if (j == ncodes * blk || (j % blk) >= 4) exp = 8'h00;
                else exp = 8'(1 << sw_codes[j / blk]);
                if (start + j < 128) chk($sformatf("%s_s%0d", nm, j), rec[start + j], exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_vld = 0; a_code = 0; a_flush = 0;
        b_vld = 0; b_code = 0; b_flush = 0;
        onehot_bad = 0;
        ov_bad = 0;

        //            vld code fl  y      rdy busy cnt
        tbl[0]  = '{1'b1, 3'd5, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 3'd7, 1'b0, 8'h20, 1'b1, 1'b1, 8'd1};
        tbl[2]  = '{1'b0, 3'd7, 1'b0, 8'h20, 1'b1, 1'b1, 8'd1};
        tbl[3]  = '{1'b0, 3'd7, 1'b0, 8'h20, 1'b1, 1'b1, 8'd1};
        tbl[4]  = '{1'b0, 3'd7, 1'b0, 8'h20, 1'b1, 1'b1, 8'd1};
        tbl[5]  = '{1'b0, 3'd7, 1'b0, 8'h00, 1'b1, 1'b1, 8'd1};
        tbl[6]  = '{1'b0, 3'd7, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1};
        tbl[7]  = '{1'b1, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd1};
        tbl[8]  = '{1'b1, 3'd2, 1'b0, 8'h02, 1'b1, 1'b1, 8'd2};
        tbl[9]  = '{1'b1, 3'd2, 1'b0, 8'h02, 1'b0, 1'b1, 8'd2};
        tbl[10] = '{1'b0, 3'd0, 1'b0, 8'h02, 1'b0, 1'b1, 8'd2};
        tbl[11] = '{1'b0, 3'd0, 1'b0, 8'h02, 1'b0, 1'b1, 8'd2};
        tbl[12] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd2};
        tbl[13] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 8'd3};
        tbl[14] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 8'd3};
        tbl[15] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 8'd3};
        tbl[16] = '{1'b0, 3'd0, 1'b0, 8'h04, 1'b1, 1'b1, 8'd3};
        tbl[17] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd3};
        tbl[18] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd3};
        tbl[19] = '{1'b1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b1, 8'd3};
        tbl[20] = '{1'b0, 3'd6, 1'b0, 8'h10, 1'b1, 1'b1, 8'd4};
        tbl[21] = '{1'b1, 3'd2, 1'b0, 8'h10, 1'b0, 1'b1, 8'd4};
        tbl[22] = '{1'b1, 3'd7, 1'b1, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[23] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[24] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[25] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[26] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[27] = '{1'b0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[28] = '{1'b1, 3'd3, 1'b1, 8'h00, 1'b1, 1'b0, 8'd4};
        tbl[29] = '{1'b0, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4};

        // Reset state, asserted before any clock edge.
        #1;
        chk("rst_y",    a_y,   8'h00);
        chk("rst_ov",   8'(a_ov), 8'd0);
        chk("rst_rdy",  8'(a_rdy), 8'd1);
        chk("rst_busy", 8'(a_busy), 8'd0);
        chk("rst_cnt",  a_cnt, 8'd0);
        #11 rst_n = 1'b1;

        // Single code, backpressure, flush.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            a_vld = tbl[i].vld; a_code = tbl[i].code; a_flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_y", i),    a_y,   tbl[i].y);
            chk($sformatf("tbl%0d_ov", i),   8'(a_ov), 8'(tbl[i].y != 8'h00));
            chk($sformatf("tbl%0d_rdy", i),  8'(a_rdy), 8'(tbl[i].rdy));
            chk($sformatf("tbl%0d_busy", i), 8'(a_busy), 8'(tbl[i].busy));
            chk($sformatf("tbl%0d_cnt", i),  a_cnt, tbl[i].cnt);
        end
        @(negedge clk);
        a_vld = 1'b0; a_flush = 1'b0;

        // Sweep 7..0 with GAP=1.
        for (int i = 0; i < 8; i++) sw_codes[i] = 7 - i;
        stream(1'b0, 8, 60);
        check_seq("sweep", 8, 1);
        chk("sweep_cnt", a_cnt, 8'd12);

        // GAP=0 back-to-back.
        sw_codes[0] = 3; sw_codes[1] = 6;
        stream(1'b1, 2, 30);
        check_seq("b2b", 2, 0);
        chk("b2b_cnt", b_cnt, 8'd2);

        // Asynchronous reset mid-HOLD with a code pending.
        @(negedge clk); a_vld = 1'b1; a_code = 3'd6;
        @(posedge clk); #1;
        @(negedge clk); a_code = 3'd1;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("mid_hold_y", a_y, 8'h40);
        chk("mid_hold_rdy", 8'(a_rdy), 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y",    a_y,   8'h00);
        chk("arst_ov",   8'(a_ov), 8'd0);
        chk("arst_cnt",  a_cnt, 8'd0);
        chk("arst_rdy",  8'(a_rdy), 8'd1);
        chk("arst_busy", 8'(a_busy), 8'd0);
        a_code = 3'd0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_accept_rdy", 8'(a_rdy), 8'd0);
        chk("first_edge_accept_y",   a_y, 8'h00);
        @(negedge clk); a_vld = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_y",   a_y,   8'h01);
        chk("post_rst_cnt", a_cnt, 8'd1);

        // 256 codes through the GAP=0 instance: counter wraps to zero.
        for (int i = 0; i < 256; i++) sw_codes[i] = i % 8;
        stream(1'b1, 256, 1100);
        for (int k = 0; k < 50 && b_busy; k++) @(posedge clk);
        #1;
        chk("wrap_idle", 8'(b_busy), 8'd0);
        chk("wrap_cnt",  b_cnt, 8'd0);

        chk("onehot_violations", 8'(onehot_bad), 8'd0);
        chk("out_valid_violations", 8'(ov_bad), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
